// File: rtl/wb_burst_master.sv
// Wishbone pipelined burst initiator: turns one command plus a word stream into
// a single or 1..16-word burst, with read data return and a bus-idle timeout.
module wb_burst_master #(
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // Wishbone pipelined master side
  output logic             bus_cyc,
  output logic             bus_stb,
  output logic             bus_we,
  output logic [31:0]      bus_adr,
  output logic [3:0]       bus_sel,
  output logic [31:0]      bus_dat_m,
  input  logic [31:0]      bus_dat_s,
  input  logic             bus_ack,
  input  logic             bus_stall,
  // command / stream side
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_adr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             timeout_err,
  output logic             busy
);

  localparam int unsigned CNT_W = LEN_W + 1;
  localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t             state, state_n;
  logic               we_q, we_n;
  logic [31:0]        adr_q, adr_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic [CNT_W-1:0]   issued, issued_n;
  logic [CNT_W-1:0]   acked, acked_n;
  logic [TMO_W-1:0]   tmo, tmo_n;
  logic               tmo_err, tmo_err_n;
  logic [31:0]        rd_data_q, rd_data_n;
  logic               rd_valid_q, rd_valid_n;

  logic [CNT_W-1:0]   len_ext;
  logic               accept;
  logic               ack_v;
  logic               last_ack;
  logic               last_issue;

  // Bus outputs follow the state register; write data passes straight through.
  always_comb begin
    len_ext     = {1'b0, len_q};
    bus_cyc     = (state == S_ISSUE) || (state == S_WAIT);
    bus_stb     = (state == S_ISSUE) && (!we_q || wr_valid);
    bus_we      = we_q;
    bus_adr     = adr_q;
    bus_sel     = bus_cyc ? 4'hf : 4'h0;
    bus_dat_m   = ((state == S_ISSUE) && we_q) ? wr_data : 32'h0;
    accept      = bus_stb && !bus_stall;
    ack_v       = bus_cyc && bus_ack && (acked != (len_ext + CNT_W'(1)));
    last_ack    = ack_v && (acked == len_ext);
    last_issue  = accept && (issued == len_ext);
    wr_ready    = accept && we_q;
    cmd_ready   = (state == S_IDLE);
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    timeout_err = (state == S_DONE) && tmo_err;
    rd_data     = rd_data_q;
    rd_valid    = rd_valid_q;
  end

  // Next-state and counter logic
  always_comb begin
    state_n    = state;
    we_n       = we_q;
    adr_n      = adr_q;
    len_n      = len_q;
    issued_n   = issued;
    acked_n    = acked;
    tmo_n      = tmo;
    tmo_err_n  = tmo_err;
    rd_data_n  = rd_data_q;
    rd_valid_n = 1'b0;

    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          we_n      = cmd_we;
          adr_n     = cmd_adr & 32'hffff_fffc;
          len_n     = cmd_len;
          issued_n  = '0;
          acked_n   = '0;
          tmo_n     = '0;
          tmo_err_n = 1'b0;
          state_n   = S_ISSUE;
        end
      end
      S_ISSUE, S_WAIT: begin
        if (accept) begin
          issued_n = issued + CNT_W'(1);
          adr_n    = adr_q + 32'd4;
        end
        if (ack_v) begin
          acked_n = acked + CNT_W'(1);
          if (!we_q) begin
            rd_valid_n = 1'b1;
            rd_data_n  = bus_dat_s;
          end
        end
        tmo_n = (accept || ack_v) ? '0 : tmo + TMO_W'(1);
        // Completion wins over timeout; the final ack may land while still issuing.
        if (last_ack) begin
          state_n = S_DONE;
        end else if (tmo == TMO_LIMIT) begin
          state_n   = S_DONE;
          tmo_err_n = 1'b1;
        end else if ((state == S_ISSUE) && last_issue) begin
          state_n = S_WAIT;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      adr_q      <= '0;
      len_q      <= '0;
      issued     <= '0;
      acked      <= '0;
      tmo        <= '0;
      tmo_err    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state      <= state_n;
      we_q       <= we_n;
      adr_q      <= adr_n;
      len_q      <= len_n;
      issued     <= issued_n;
      acked      <= acked_n;
      tmo        <= tmo_n;
      tmo_err    <= tmo_err_n;
      rd_data_q  <= rd_data_n;
      rd_valid_q <= rd_valid_n;
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master: behavioural slave with stall/latency
// knobs, expected bus requests/read words/completions queued per command.
module tb_wb_burst_master;

  localparam int unsigned LEN_W = 4;
  localparam int unsigned TMO   = 8;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             bus_cyc, bus_stb, bus_we;
  logic [31:0]      bus_adr;
  logic [3:0]       bus_sel;
  logic [31:0]      bus_dat_m;
  logic [31:0]      bus_dat_s;
  logic             bus_ack, bus_stall;
  logic             cmd_valid, cmd_ready, cmd_we;
  logic [31:0]      cmd_adr;
  logic [LEN_W-1:0] cmd_len;
  logic [31:0]      wr_data;
  logic             wr_valid, wr_ready;
  logic [31:0]      rd_data;
  logic             rd_valid, done, timeout_err, busy;

  wb_burst_master #(.LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_adr(bus_adr),
    .bus_sel(bus_sel), .bus_dat_m(bus_dat_m), .bus_dat_s(bus_dat_s),
    .bus_ack(bus_ack), .bus_stall(bus_stall),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] adr; logic we; } req_t;
  typedef struct { int due; logic [31:0] data; } pend_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           cycle   = 0;
  req_t         exp_req[$];
  logic [31:0]  exp_wd[$];
  logic [31:0]  exp_rd[$];
  logic         exp_done[$];
  logic [31:0]  wr_q[$];
  logic [31:0]  wdata_src[$];
  pend_t        pend[$];
  logic [31:0]  model_mem[64];
  logic [31:0]  slave_mem[64];
  int           stall_mode = 0;
  int           lat        = 1;
  int           wr_mode    = 0;
  bit           ack_en     = 1'b1;
  bit           force_ack  = 1'b0;
  int           last_acc_cycle = 0;
  int           cyc_fall_cycle = 0;
  logic         cyc_prev = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event not expected or bound expired (cycle %0d)", name, cycle);
  endtask

  // Behavioural slave plus write-stream source
  initial begin : slave
    int   streak;
    int   wgap;
    pend_t p;
    logic [5:0] idx;
    streak = 0; wgap = 0;
    bus_stall = 1'b0; bus_ack = 1'b0; bus_dat_s = '0;
    wr_valid = 1'b0; wr_data = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        pend.delete();
      end else if (bus_cyc && bus_stb && !bus_stall) begin
        idx = bus_adr[7:2];
        p.due = cycle + lat;
        if (bus_we) begin
          slave_mem[idx] = bus_dat_m;
          p.data = '0;
          if (wr_q.size() > 0) void'(wr_q.pop_front());
        end else begin
          p.data = slave_mem[idx];
        end
        if (ack_en) pend.push_back(p);
      end
      @(posedge clk);
      #1;
      bus_ack   = 1'b0;
      bus_dat_s = $urandom;
      if (force_ack) begin
        bus_ack = 1'b1;
      end else if (pend.size() > 0 && pend[0].due <= cycle) begin
        bus_ack   = 1'b1;
        bus_dat_s = pend[0].data;
        void'(pend.pop_front());
      end
      case (stall_mode)
        0: bus_stall = 1'b0;
        1: bus_stall = ~bus_stall;
        default: begin
          bus_stall = (streak >= 2) ? 1'b0 : 1'($urandom % 2);
          streak    = bus_stall ? streak + 1 : 0;
        end
      endcase
      if (wr_q.size() > 0) begin
        case (wr_mode)
          0: wr_valid = 1'b1;
          1: wr_valid = ~wr_valid;
          default: begin
            wr_valid = (wgap >= 1) ? 1'b1 : 1'($urandom % 2);
            wgap     = wr_valid ? 0 : wgap + 1;
          end
        endcase
        wr_data = wr_valid ? wr_q[0] : $urandom;
      end else begin
        wr_valid = 1'b0;
        wr_data  = $urandom;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents something
  always @(negedge clk) begin : monitor
    req_t        e;
    logic [31:0] w;
    logic        acc;
    if (cyc_prev && !bus_cyc) cyc_fall_cycle = cycle;
    cyc_prev = bus_cyc;
    if (!rst_i) begin
      acc = bus_cyc && bus_stb && !bus_stall;
      if (acc) begin
        last_acc_cycle = cycle;
        if (exp_req.size() == 0) fail_now("unexpected_request");
        else begin
          e = exp_req.pop_front();
          chk("req_adr", bus_adr, e.adr);
          chk("req_we", 32'(bus_we), 32'(e.we));
          chk("req_sel", 32'(bus_sel), 32'h0000_000f);
          if (bus_we) begin
            chk("wr_ready_on_accept", 32'(wr_ready), 32'd1);
            if (exp_wd.size() == 0) fail_now("unexpected_write_word");
            else begin
              w = exp_wd.pop_front();
              chk("wr_word", bus_dat_m, w);
            end
          end
        end
      end else if (bus_cyc) begin
        chk("wr_ready_idle", 32'(wr_ready), 32'd0);
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) fail_now("unexpected_rd_valid");
        else begin
          w = exp_rd.pop_front();
          chk("rd_data", rd_data, w);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) fail_now("unexpected_done");
        else begin
          chk("timeout_err", 32'(timeout_err), 32'(exp_done.pop_front()));
          chk("cyc_low_at_done", 32'(bus_cyc), 32'd0);
        end
      end
    end
  end

  // Queue the reference expectations for a command, drive it and wait for done.
  task automatic do_cmd(input logic we, input logic [31:0] adr, input int len,
                        input int sm, input int l, input int wm, input bit no_ack,
                        output int lat_c);
    logic [31:0] base, a, w;
    logic [5:0]  idx;
    req_t        r;
    bit          got;
    int          t0;
    stall_mode = sm; lat = l; wr_mode = wm;
    base = adr & 32'hffff_fffc;
    for (int i = 0; i <= len; i++) begin
      a = base + 32'(4 * i);
      idx = a[7:2];
      r.adr = a; r.we = we;
      exp_req.push_back(r);
      if (we) begin
        w = (wdata_src.size() > 0) ? wdata_src.pop_front() : $urandom;
        model_mem[idx] = w;
        exp_wd.push_back(w);
        wr_q.push_back(w);
      end else if (!no_ack) begin
        exp_rd.push_back(model_mem[idx]);
      end
    end
    exp_done.push_back(no_ack);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = LEN_W'(len);
    got = 1'b0; t0 = 0; lat_c = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1'b1; t0 = cycle; break; end
    end
    if (!got) fail_now("cmd_accept_bound");
    got = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'($urandom % 2); cmd_we = 1'($urandom % 2);
      cmd_adr = $urandom; cmd_len = LEN_W'($urandom);
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    if (!got) fail_now("done_bound");
    lat_c = cycle - t0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("req_left", 32'(exp_req.size()), 32'd0);
    chk("rd_left", 32'(exp_rd.size()), 32'd0);
    chk("done_left", 32'(exp_done.size()), 32'd0);
    chk("wr_stream_left", 32'(wr_q.size()), 32'd0);
    exp_req.delete(); exp_rd.delete(); exp_done.delete(); exp_wd.delete(); wr_q.delete();
  endtask

  initial begin : stim
    int   lc, dur, n;
    bit   got;
    logic rw;
    int   sm, wm;
    rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0;
    for (int i = 0; i < 64; i++) begin
      model_mem[i] = $urandom;
      slave_mem[i] = model_mem[i];
    end
    model_mem[4] = 32'h1; slave_mem[4] = 32'h1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", 32'(bus_cyc), 32'd0);
    chk("rst_stb", 32'(bus_stb), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_adr", bus_adr, 32'd0);
    chk("rst_sel", 32'(bus_sel), 32'd0);
    chk("rst_dat_m", bus_dat_m, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1; rst_i = 1'b0;

    // single read of the LED register, zero-wait slave
    do_cmd(1'b0, 32'h0000_0010, 0, 0, 1, 0, 1'b0, lc);
    chk("single_read_latency", 32'(lc), 32'd3);
    // single write then read back
    wdata_src.push_back(32'h1);
    do_cmd(1'b1, 32'h0000_0000, 0, 0, 1, 0, 1'b0, lc);
    do_cmd(1'b0, 32'h0000_0003, 0, 0, 1, 0, 1'b0, lc);
    // wrapping 4-word read, stall every other cycle, 2-cycle ack latency
    do_cmd(1'b0, 32'hffff_fff8, 3, 1, 2, 0, 1'b0, lc);
    // 16-word write with toggling stream, then read it back
    do_cmd(1'b1, 32'h0000_0040, 15, 0, 1, 1, 1'b0, lc);
    do_cmd(1'b0, 32'h0000_0040, 15, 2, 3, 0, 1'b0, lc);
    // randomized commands
    for (int t = 0; t < 14; t++) begin
      rw = 1'($urandom % 2);
      wm = int'($urandom % 3);
      sm = int'($urandom % 3);
      if (rw && wm != 0) sm = 0;
      do_cmd(rw, $urandom, int'($urandom % 16), sm, int'($urandom_range(1, 3)), wm, 1'b0, lc);
    end

    // slave never acks: timeout, then stray acks while idle
    ack_en = 1'b0;
    do_cmd(1'b0, 32'h0000_0100, 3, 0, 1, 0, 1'b1, lc);
    dur = cyc_fall_cycle - last_acc_cycle - 1;
    chk("timeout_idle_cycles_in_range", 32'((dur >= int'(TMO)) && (dur <= int'(TMO) + 1)), 32'd1);
    ack_en = 1'b1;
    @(posedge clk); #1; force_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("late_ack_busy", 32'(busy), 32'd0);
    end
    @(posedge clk); #1; force_ack = 1'b0;
    repeat (2) @(negedge clk);

    // reset during the third word of an 8-word read
    stall_mode = 0; lat = 3;
    for (int i = 0; i < 8; i++) begin
      req_t r;
      r.adr = 32'h0000_0200 + 32'(4 * i); r.we = 1'b0;
      exp_req.push_back(r);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h0000_0200; cmd_len = LEN_W'(7);
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1'b1; break; end
    end
    if (!got) fail_now("rst_cmd_accept_bound");
    @(posedge clk); #1; cmd_valid = 1'b0;
    n = 0; got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus_cyc && bus_stb && !bus_stall) n++;
      if (n == 3) begin got = 1'b1; break; end
    end
    if (!got) fail_now("third_word_bound");
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrst_cyc", 32'(bus_cyc), 32'd0);
    chk("midrst_stb", 32'(bus_stb), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(posedge clk); #1; rst_i = 1'b0;
    exp_req.delete(); exp_rd.delete(); exp_done.delete();
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("post_rst_done", 32'(done), 32'd0);
    end
    do_cmd(1'b0, 32'h0000_0010, 0, 0, 1, 0, 1'b0, lc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
